serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_W = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor, LSB first, start/busy/done handshake.
// Optional two's-complement overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CNT_W = $clog2(N) + 1;

  state_t             state, state_nxt;
  logic [N-1:0]       sa, sb, res, res_nxt;
  logic               bff;
  logic [CNT_W-1:0]   cnt;
  logic               d, bo, last, accept;

  full_subtractor u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bff),
    .d    (d),
    .bout (bo)
  );

  assign last   = (cnt == CNT_W'(N - 1));
  assign accept = start && (state == IDLE || state == DONE);

  // Result fills from the MSB so that after N shifts bit 0 holds the first LSB.
  always_comb begin
    res_nxt        = res >> 1;
    res_nxt[N-1]   = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      bff        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      res <= '0;
      bff <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      res <= res_nxt;
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      bff <= bo;
      cnt <= cnt + 1'b1;
      // Outputs update only on the edge that enters DONE and then hold.
      if (last) begin
        diff       <= res_nxt;
        borrow_out <= bo;
`ifdef SERIAL_SUB_OVF_EN
        ovf        <= bff ^ bo;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (N=8).
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         busy, done, borrow_out;
  logic [N-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int nchk = 0;
  int nerr = 0;

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a start at the current point (caller is at a negedge); drop it after the edge.
  task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'h5A;
    b     = 8'hC3;
  endtask

  // Count negedges from the accept edge until done, with a bound.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) break;
    end
    if (!done) chk("timeout_done", 32'(done), 32'd1);
  endtask

  task automatic op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                    input logic [N-1:0] ed, input logic eb);
    int cyc, bcnt;
    @(negedge clk);
    launch(av, bv);
    wait_done(cyc, bcnt);
    chk({tag, "_lat"},  32'(cyc),        32'd9);
    chk({tag, "_busy"}, 32'(bcnt),       32'd8);
    chk({tag, "_diff"}, 32'(diff),       32'(ed));
    chk({tag, "_bo"},   32'(borrow_out), 32'(eb));
  endtask

  initial begin
    int cyc, bcnt, ndone;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bo",   32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf",  32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // Basic operation and single-cycle done with held result
    op("t1", 8'd100, 8'd37, 8'h3F, 1'b0);
    @(negedge clk);
    chk("t1_pulse", 32'(done), 32'd0);
    chk("t1_hold",  32'(diff), 32'h3F);

    // Borrow cases
    op("t2a", 8'd5, 8'd9, 8'hFC, 1'b1);
    op("t2b", 8'h00, 8'hFF, 8'h01, 1'b1);

    // Equal operands, then back-to-back restart from DONE
    op("t3a", 8'hA5, 8'hA5, 8'h00, 1'b0);
    launch(8'd200, 8'd1);
    chk("t3_hold_run", 32'(diff), 32'h00);
    chk("t3_busy",     32'(busy), 32'd1);
    wait_done(cyc, bcnt);
    chk("t3b_lat",  32'(cyc),  32'd9);
    chk("t3b_diff", 32'(diff), 32'd199);
    chk("t3b_bo",   32'(borrow_out), 32'd0);

    // Start during RUN is ignored
    @(negedge clk);
    launch(8'd100, 8'd37);
    repeat (3) @(negedge clk);
    launch(8'd1, 8'd1);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("t4_diff", 32'(diff), 32'h3F);
      end
    end
    chk("t4_ndone", 32'(ndone), 32'd1);

    // Reset mid-RUN aborts
    op("t5pre", 8'd200, 8'd1, 8'd199, 1'b0);
    @(negedge clk);
    launch(8'd5, 8'd9);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_diff", 32'(diff), 32'd0);
    chk("t5_bo",   32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_nodone", 32'(ndone), 32'd0);

    // Recovery after abort
    op("t5post", 8'd100, 8'd37, 8'h3F, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    op("t6a", 8'h80, 8'h01, 8'h7F, 1'b0);
    chk("t6a_ovf", 32'(ovf), 32'd1);
    op("t6b", 8'h10, 8'h01, 8'h0F, 1'b0);
    chk("t6b_ovf", 32'(ovf), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
